// File: rtl/avalon_pkt_fifo.sv
// avalon_pkt_fifo
//   Store-and-forward Avalon-ST packet buffer placed in front of the packet
//   sorter. The sink never backpressures; malformed packets (missing EOP,
//   longer than MAX_PKT_LEN, or overflowing the buffer) are dropped and
//   counted. Only complete, committed packets are presented on the source.
//
// Ports
//   clk_i                 clock, rising edge
//   srst_i                asynchronous active-high reset
//   snk_data_i/_startofpacket_i/_endofpacket_i/_valid_i  upstream beat
//   snk_ready_o           1 whenever out of reset
//   src_data_o/_startofpacket_o/_endofpacket_o/_valid_o  beat to sorter
//   src_ready_i           sorter ready
//   drop_cnt_o            dropped-packet count, saturating
//   pkt_cnt_o             complete packets currently held
module avalon_pkt_fifo #(
  parameter int DWIDTH      = 32,
  parameter int MAX_PKT_LEN = 300,
  parameter int DEPTH       = 512
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [DWIDTH-1:0]          snk_data_i,
  input  logic                       snk_startofpacket_i,
  input  logic                       snk_endofpacket_i,
  input  logic                       snk_valid_i,
  output logic                       snk_ready_o,
  output logic [DWIDTH-1:0]          src_data_o,
  output logic                       src_startofpacket_o,
  output logic                       src_endofpacket_o,
  output logic                       src_valid_o,
  input  logic                       src_ready_i,
  output logic [15:0]                drop_cnt_o,
  output logic [$clog2(DEPTH):0]     pkt_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT_LEN + 1);
  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
  localparam logic [LW-1:0] MAX_LEN_P = LW'(MAX_PKT_LEN);

  typedef enum logic [1:0] {IDLE_W, WRITE_W, DISCARD_W} wr_state_t;

  wr_state_t         state, state_n;
  logic [PW-1:0]     wr_ptr, wr_ptr_n;
  logic [PW-1:0]     commit_ptr, commit_ptr_n;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     len, len_n;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic              commit_ev, drop_ev;
  logic              beat, full, commit_full;

  logic              rdy_q;
  logic [15:0]       drop_cnt;
  logic [PW-1:0]     pkt_cnt;

  logic [DWIDTH:0]   mem [DEPTH];
  logic [DWIDTH:0]   ram_q;
  logic              s1_vld;
  logic              out_vld, out_sop, out_eop;
  logic [DWIDTH-1:0] out_data;
  logic              sop_pending;
  logic              xfer, eop_xfer, out_load, rd_en, rd_avail;

  assign beat        = snk_valid_i && rdy_q;
  assign full        = (wr_ptr - rd_ptr) == DEPTH_P;
  assign commit_full = (commit_ptr - rd_ptr) == DEPTH_P;

  // Beat decode for the write FSM. Every SOP starts a packet at commit_ptr
  // (in IDLE_W/DISCARD_W wr_ptr already equals commit_ptr), so the restart
  // case in WRITE_W shares the same path. A start is refused only when the
  // committed data alone fills the buffer, so stored packets are never hit.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    len_n        = len;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr[AW-1:0];
    commit_ev    = 1'b0;
    drop_ev      = 1'b0;
    if (beat) begin
      if (snk_startofpacket_i) begin
        if (state == WRITE_W) drop_ev = 1'b1;
        wr_ptr_n = commit_ptr;
        if (commit_full) begin
          drop_ev = 1'b1;
          state_n = snk_endofpacket_i ? IDLE_W : DISCARD_W;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = commit_ptr[AW-1:0];
          wr_ptr_n  = commit_ptr + 1'b1;
          len_n     = LW'(1);
          if (snk_endofpacket_i) begin
            commit_ev    = 1'b1;
            commit_ptr_n = commit_ptr + 1'b1;
            state_n      = IDLE_W;
          end else begin
            state_n = WRITE_W;
          end
        end
      end else begin
        case (state)
          WRITE_W: begin
            if (len == MAX_LEN_P || full) begin
              drop_ev  = 1'b1;
              wr_ptr_n = commit_ptr;
              state_n  = snk_endofpacket_i ? IDLE_W : DISCARD_W;
            end else begin
              mem_we   = 1'b1;
              wr_ptr_n = wr_ptr + 1'b1;
              len_n    = len + 1'b1;
              if (snk_endofpacket_i) begin
                commit_ev    = 1'b1;
                commit_ptr_n = wr_ptr + 1'b1;
                state_n      = IDLE_W;
              end
            end
          end
          DISCARD_W: begin
            if (snk_endofpacket_i) state_n = IDLE_W;
          end
          default: ;
        endcase
      end
    end
  end

  // Read side: RAM read register (s1) feeding a show-ahead output register.
  // s1 refills whenever it empties into the output, giving one word per cycle.
  assign xfer     = out_vld && src_ready_i;
  assign eop_xfer = xfer && out_eop;
  assign out_load = s1_vld && (!out_vld || xfer);
  assign rd_avail = commit_ptr != rd_ptr;
  assign rd_en    = rd_avail && (!s1_vld || out_load);

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= {snk_endofpacket_i, snk_data_i};
    if (rd_en)  ram_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state       <= IDLE_W;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      len         <= '0;
      rdy_q       <= 1'b0;
      drop_cnt    <= '0;
      pkt_cnt     <= '0;
      s1_vld      <= 1'b0;
      out_vld     <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_data    <= '0;
      sop_pending <= 1'b1;
    end else begin
      rdy_q      <= 1'b1;
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      len        <= len_n;

      if (drop_ev && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;

      case ({commit_ev, eop_xfer})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: ;
      endcase

      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      if (rd_en)         s1_vld <= 1'b1;
      else if (out_load) s1_vld <= 1'b0;

      // A word loaded while the current word transfers follows it directly,
      // so its SOP comes from the outgoing EOP rather than sop_pending.
      if (out_load) begin
        out_vld  <= 1'b1;
        out_data <= ram_q[DWIDTH-1:0];
        out_eop  <= ram_q[DWIDTH];
        out_sop  <= xfer ? out_eop : sop_pending;
      end else if (xfer) begin
        out_vld <= 1'b0;
      end

      if (xfer) sop_pending <= out_eop;
    end
  end

  assign snk_ready_o         = rdy_q;
  assign src_data_o          = out_data;
  assign src_startofpacket_o = out_sop;
  assign src_endofpacket_o   = out_eop;
  assign src_valid_o         = out_vld;
  assign drop_cnt_o          = drop_cnt;
  assign pkt_cnt_o           = pkt_cnt;

endmodule

// File: tb/tb_avalon_pkt_fifo.sv
// Testbench for avalon_pkt_fifo: cycle-vector table for short packets plus
// hand-written sequences for drops, overflow under backpressure and reset.
module tb_avalon_pkt_fifo;

  localparam int DW = 32;
  localparam int PW = 10;

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic [DW-1:0] snk_data_i;
  logic          snk_startofpacket_i, snk_endofpacket_i, snk_valid_i;
  logic          snk_ready_o;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o, src_endofpacket_o, src_valid_o;
  logic          src_ready_i;
  logic [15:0]   drop_cnt_o;
  logic [PW-1:0] pkt_cnt_o;

  always #5 clk_i = ~clk_i;

  avalon_pkt_fifo #(.DWIDTH(DW), .MAX_PKT_LEN(300), .DEPTH(512)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .snk_data_i(snk_data_i), .snk_startofpacket_i(snk_startofpacket_i),
    .snk_endofpacket_i(snk_endofpacket_i), .snk_valid_i(snk_valid_i),
    .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o), .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o(src_endofpacket_o), .src_valid_o(src_valid_o),
    .src_ready_i(src_ready_i),
    .drop_cnt_o(drop_cnt_o), .pkt_cnt_o(pkt_cnt_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: captures transfers and checks outputs hold while stalled.
  logic [33:0]   got_q[$];
  logic [33:0]   exp_q[$];
  logic          mon_en = 1'b0;
  logic          pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (pv && !pr) begin
        chk("hold_valid", src_valid_o, 1);
        chk("hold_data", src_data_o, pd);
        chk("hold_sop", src_startofpacket_o, ps);
        chk("hold_eop", src_endofpacket_o, pe);
      end
      if (src_valid_o && src_ready_i)
        got_q.push_back({src_startofpacket_o, src_endofpacket_o, src_data_o});
      pv = src_valid_o; pr = src_ready_i; ps = src_startofpacket_o;
      pe = src_endofpacket_o; pd = src_data_o;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input logic s, input logic e, input logic [DW-1:0] d);
    step();
    snk_valid_i = 1'b1; snk_startofpacket_i = s; snk_endofpacket_i = e; snk_data_i = d;
  endtask

  task automatic idle();
    step();
    snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0; snk_data_i = '0;
  endtask

  task automatic send_pkt(input int unsigned base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      send_beat(i == 0, i == n - 1, DW'(base + i));
  endtask

  task automatic add_pkt(input int unsigned base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      exp_q.push_back({i == 0, i == n - 1, DW'(base + i)});
  endtask

  task automatic reset_dut();
    mon_en = 1'b0;
    step();
    srst_i = 1'b1;
    step();
    step();
    srst_i = 1'b0;
    step();
    step();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_drain(input int budget, input bit rand_rdy);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      src_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk_i);
      if (pkt_cnt_o == '0 && !src_valid_o) done = 1'b1;
    end
    src_ready_i = 1'b1;
    chk("drain_done", done, 1);
  endtask

  task automatic cmp_capture(input string tag);
    int unsigned e0;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e0 = n_err;
      chk({tag, "_word"}, got_q[i], exp_q[i]);
      if (n_err != e0) break;
    end
  endtask

  typedef struct {
    logic          v, s, e;
    logic [DW-1:0] d;
    logic          rdy;
    logic          xv, xs, xe;
    logic [DW-1:0] xd;
    int unsigned   xp;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic s, input logic e,
                              input logic [DW-1:0] d, input logic rdy,
                              input logic xv, input logic xs, input logic xe,
                              input logic [DW-1:0] xd, input int unsigned xp);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.d = d; r.rdy = rdy;
    r.xv = xv; r.xs = xs; r.xe = xe; r.xd = xd; r.xp = xp;
    return r;
  endfunction

  vec_t tbl [16];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Outputs checked in row k reflect the edge before row k's inputs are taken.
    // 5-word packet 1..5, then a single-word packet 0xA5 whose commit
    // coincides with the transfer of word 5.
    tbl[0]  = mk(1, 1, 0, 32'd1,    1, 0, 0, 0, 32'd0,    0);
    tbl[1]  = mk(1, 0, 0, 32'd2,    1, 0, 0, 0, 32'd0,    0);
    tbl[2]  = mk(1, 0, 0, 32'd3,    1, 0, 0, 0, 32'd0,    0);
    tbl[3]  = mk(1, 0, 0, 32'd4,    1, 0, 0, 0, 32'd0,    0);
    tbl[4]  = mk(1, 0, 1, 32'd5,    1, 0, 0, 0, 32'd0,    0);
    tbl[5]  = mk(0, 0, 0, 32'd0,    1, 0, 0, 0, 32'd0,    1);
    tbl[6]  = mk(0, 0, 0, 32'd0,    1, 0, 0, 0, 32'd0,    1);
    tbl[7]  = mk(0, 0, 0, 32'd0,    1, 1, 1, 0, 32'd1,    1);
    tbl[8]  = mk(0, 0, 0, 32'd0,    1, 1, 0, 0, 32'd2,    1);
    tbl[9]  = mk(0, 0, 0, 32'd0,    1, 1, 0, 0, 32'd3,    1);
    tbl[10] = mk(0, 0, 0, 32'd0,    1, 1, 0, 0, 32'd4,    1);
    tbl[11] = mk(1, 1, 1, 32'hA5,   1, 1, 0, 1, 32'd5,    1);
    tbl[12] = mk(0, 0, 0, 32'd0,    1, 0, 0, 0, 32'd0,    1);
    tbl[13] = mk(0, 0, 0, 32'd0,    1, 0, 0, 0, 32'd0,    1);
    tbl[14] = mk(0, 0, 0, 32'd0,    1, 1, 1, 1, 32'hA5,   1);
    tbl[15] = mk(0, 0, 0, 32'd0,    1, 0, 0, 0, 32'd0,    0);

    srst_i = 1'b1;
    snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
    snk_data_i = '0; src_ready_i = 1'b0;
    step();
    step();
    @(negedge clk_i);
    chk("rst_snk_ready", snk_ready_o, 0);
    chk("rst_src_valid", src_valid_o, 0);
    chk("rst_pkt_cnt", pkt_cnt_o, 0);
    chk("rst_drop_cnt", drop_cnt_o, 0);
    step();
    srst_i = 1'b0;
    step();
    step();
    @(negedge clk_i);
    chk("snk_ready_up", snk_ready_o, 1);

    // Table-driven short packets.
    for (int k = 0; k < 16; k++) begin
      step();
      snk_valid_i = tbl[k].v; snk_startofpacket_i = tbl[k].s;
      snk_endofpacket_i = tbl[k].e; snk_data_i = tbl[k].d;
      src_ready_i = tbl[k].rdy;
      @(negedge clk_i);
      chk($sformatf("vec%0d_valid", k), src_valid_o, tbl[k].xv);
      chk($sformatf("vec%0d_pkt_cnt", k), pkt_cnt_o, tbl[k].xp);
      if (tbl[k].xv) begin
        chk($sformatf("vec%0d_data", k), src_data_o, tbl[k].xd);
        chk($sformatf("vec%0d_sop", k), src_startofpacket_o, tbl[k].xs);
        chk($sformatf("vec%0d_eop", k), src_endofpacket_o, tbl[k].xe);
      end
    end
    idle();
    @(negedge clk_i);
    chk("vec_drop_cnt", drop_cnt_o, 0);

    // 301-word packet is dropped, following 3-word packet survives.
    reset_dut();
    src_ready_i = 1'b1;
    mon_en = 1'b1;
    send_pkt(32'h1000, 301);
    send_pkt(32'h2000, 3);
    idle();
    add_pkt(32'h2000, 3);
    wait_drain(100, 1'b0);
    cmp_capture("oversize");
    chk("oversize_drop_cnt", drop_cnt_o, 1);

    // SOP at word 4 of an unfinished packet restarts as a 2-word packet.
    reset_dut();
    src_ready_i = 1'b1;
    mon_en = 1'b1;
    send_beat(1, 0, 32'h3000);
    send_beat(0, 0, 32'h3001);
    send_beat(0, 0, 32'h3002);
    send_pkt(32'h4000, 2);
    idle();
    add_pkt(32'h4000, 2);
    wait_drain(100, 1'b0);
    cmp_capture("missing_eop");
    chk("missing_eop_drop_cnt", drop_cnt_o, 1);

    // Three 200-word packets under 700 cycles of backpressure: third overflows.
    reset_dut();
    src_ready_i = 1'b0;
    mon_en = 1'b1;
    send_pkt(32'h5000, 200);
    send_pkt(32'h6000, 200);
    send_pkt(32'h7000, 200);
    for (int i = 0; i < 100; i++) idle();
    @(negedge clk_i);
    chk("ovf_pkt_cnt", pkt_cnt_o, 2);
    chk("ovf_drop_cnt", drop_cnt_o, 1);
    chk("ovf_valid", src_valid_o, 1);
    chk("ovf_head_data", src_data_o, 32'h5000);
    chk("ovf_head_sop", src_startofpacket_o, 1);
    add_pkt(32'h5000, 200);
    add_pkt(32'h6000, 200);
    wait_drain(3000, 1'b1);
    cmp_capture("overflow");
    chk("ovf_final_drop", drop_cnt_o, 1);

    // Reset mid-packet with a stored packet and a nonzero drop count.
    reset_dut();
    src_ready_i = 1'b0;
    send_pkt(32'h50, 2);
    send_beat(1, 0, 32'h60);
    send_beat(0, 0, 32'h61);
    send_beat(1, 0, 32'h70);
    send_beat(0, 0, 32'h71);
    idle();
    idle();
    idle();
    @(negedge clk_i);
    chk("pre_rst_valid", src_valid_o, 1);
    chk("pre_rst_pkt_cnt", pkt_cnt_o, 1);
    chk("pre_rst_drop_cnt", drop_cnt_o, 1);
    chk("pre_rst_data", src_data_o, 32'h50);
    send_beat(0, 0, 32'h72);
    srst_i = 1'b1;
    #1;
    chk("async_snk_ready", snk_ready_o, 0);
    chk("async_src_valid", src_valid_o, 0);
    chk("async_src_sop", src_startofpacket_o, 0);
    chk("async_src_eop", src_endofpacket_o, 0);
    chk("async_src_data", src_data_o, 0);
    chk("async_pkt_cnt", pkt_cnt_o, 0);
    chk("async_drop_cnt", drop_cnt_o, 0);
    idle();
    srst_i = 1'b0;
    step();
    step();
    @(negedge clk_i);
    chk("post_rst_snk_ready", snk_ready_o, 1);
    got_q.delete();
    exp_q.delete();
    src_ready_i = 1'b1;
    mon_en = 1'b1;
    send_pkt(32'h8000, 4);
    idle();
    add_pkt(32'h8000, 4);
    wait_drain(100, 1'b0);
    cmp_capture("post_rst");
    chk("post_rst_drop_cnt", drop_cnt_o, 0);
    chk("post_rst_pkt_cnt", pkt_cnt_o, 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
